// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access path.
// Both the load/store sequencer and the fetch-side range checker use them.
package mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int RD_W   = 3;

  localparam logic [ADDR_W-1:0] DATA_LO_ADDR = 8'd64;
  localparam logic [ADDR_W-1:0] DATA_HI_ADDR = 8'd127;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STORE   = 3'd1,
    LOAD    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/addr_range_check.sv
// Combinational window check: in_range is high when addr lies in [ADDR_LO, ADDR_HI].
// The comparison is unsigned.
module addr_range_check
  import mem_pkg::*;
#(
  parameter int                ADDR_W  = mem_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_LO = mem_pkg::DATA_LO_ADDR,
  parameter logic [ADDR_W-1:0] ADDR_HI = mem_pkg::DATA_HI_ADDR
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  assign in_range = (addr >= ADDR_LO) && (addr <= ADDR_HI);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of data_memory.
// Range-checks each request, drives the RAM pins and returns load data to write-back.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int                DATA_W  = mem_pkg::DATA_W,
  parameter int                ADDR_W  = mem_pkg::ADDR_W,
  parameter int                RD_W    = mem_pkg::RD_W,
  parameter logic [ADDR_W-1:0] ADDR_LO = mem_pkg::DATA_LO_ADDR,
  parameter logic [ADDR_W-1:0] ADDR_HI = mem_pkg::DATA_HI_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

  state_t          r_state;
  logic [RD_W-1:0] r_pendRd;
  logic            w_inRange;
  logic            w_accept;

  addr_range_check #(
    .ADDR_W  (ADDR_W),
    .ADDR_LO (ADDR_LO),
    .ADDR_HI (ADDR_HI)
  ) u_rangeCheck (
    .addr     (req_addr),
    .in_range (w_inRange)
  );

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  // Pulse outputs default low each cycle; mem_address and wb_* hold between transactions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_pendRd         <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      wb_valid         <= 1'b0;
      wb_rd            <= '0;
      wb_data          <= '0;
      fault            <= 1'b0;
      fault_addr       <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      wb_valid         <= 1'b0;
      fault            <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_inRange) begin
              mem_address <= req_addr;
              if (req_is_store) begin
                mem_write_data   <= req_wdata;
                mem_write_enable <= 1'b1;
                r_state          <= STORE;
              end else begin
                r_pendRd <= req_rd;
                r_state  <= LOAD;
              end
            end else begin
              fault      <= 1'b1;
              fault_addr <= req_addr;
            end
          end
        end
        STORE:   r_state <= IDLE;
        LOAD:    r_state <= CAPTURE;
        // The RAM's registered read_data is valid this cycle.
        CAPTURE: begin
          wb_data  <= mem_read_data;
          wb_rd    <= r_pendRd;
          wb_valid <= 1'b1;
          r_state  <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of data_memory.
- Accepts one load or store request from the execute stage per transaction and range-checks the address against the data RAM window (64..127).
- Drives data_memory's address, write_data and write_enable pins, and captures the registered read_data one cycle after a read.
- Returns load results to the register-file write-back port with the destination register index.

Parameters:
- DATA_W, 8, data width; matches the data_memory word.
- ADDR_W, 8, address width.
- RD_W, 3, destination register index width.
- ADDR_LO, 64, lowest legal data address.
- ADDR_HI, 127, highest legal data address.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request this cycle.
- req_is_store  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_rd  in  RD_W  load destination register.
- mem_address  out  ADDR_W  to data_memory data_address.
- mem_write_data  out  DATA_W  to data_memory write_data.
- mem_write_enable  out  1  to data_memory write_enable.
- mem_read_data  in  DATA_W  from data_memory read_data (registered in the memory).
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_rd  out  RD_W  load destination register.
- wb_data  out  DATA_W  load result.
- fault  out  1  one-cycle pulse: out-of-range access rejected.
- fault_addr  out  ADDR_W  address of the most recent faulting request.

Behaviour:
- All outputs are registered, except req_ready, which is decoded from state.
- Reset (async, reset_n=0):
  - state = IDLE.
  - mem_address = 0, mem_write_data = 0, mem_write_enable = 0.
  - wb_valid = 0, wb_rd = 0, wb_data = 0, fault = 0, fault_addr = 0.
  - An in-flight request is dropped. A store in flight is not committed if reset asserts before its write edge.
- States: IDLE, STORE, LOAD, CAPTURE, RESP.
- req_ready = 1 only in IDLE. A request is accepted at the edge where req_valid && req_ready.
- Range check at accept: legal iff ADDR_LO <= req_addr <= ADDR_HI (unsigned).
  - Illegal (cycle N accept): no memory access, state stays IDLE, mem_write_enable stays 0.
  - In cycle N+1: fault = 1 and fault_addr = req_addr. No wb_valid pulse.
  - fault_addr holds until the next fault.
  - A new request may be accepted in N+1.
- Store, accepted in cycle N:
  - Cycle N+1: state STORE, mem_address = req_addr, mem_write_data = req_wdata, mem_write_enable = 1. The memory commits at the end of N+1.
  - Cycle N+2: mem_write_enable = 0, state IDLE, req_ready = 1.
  - Throughput: one store per 2 cycles.
- Load, accepted in cycle N:
  - Cycle N+1: state LOAD, mem_address = req_addr, mem_write_enable = 0. The memory registers read_data at the end of N+1.
  - Cycle N+2: state CAPTURE. mem_read_data is valid; the unit latches it into wb_data and req_rd into wb_rd.
  - Cycle N+3: state RESP, wb_valid = 1 for exactly one cycle.
  - Cycle N+4: state IDLE.
  - Load latency: 3 cycles from accept to wb_valid. Throughput: one load per 4 cycles.
- wb_data and wb_rd hold their last values after wb_valid drops.
- mem_address holds its last value in IDLE. mem_write_enable is 0 in every state except STORE.
- Store followed by load to the same address:
  - The store commits before the unit returns to IDLE, so the load returns the new data.
  - No forwarding logic is required.
- req_valid while busy is ignored; the requester must hold the request until req_ready.
- Only the low ADDR_W bits are used; there is no wrap-around and no address arithmetic inside the unit.
- Illegal req_is_store values do not exist (1-bit). X on req_valid during reset is ignored.

Decomposition:
- Shared package mem_pkg:
  - state encoding enum (IDLE=0, STORE=1, LOAD=2, CAPTURE=3, RESP=4, 3 bits).
  - constants DATA_LO_ADDR=64, DATA_HI_ADDR=127.
  - DATA_W, ADDR_W, RD_W.
- One natural sub-module: addr_range_check (combinational; inputs addr, outputs in_range), reused later by the instruction-fetch side.
- FSM and datapath registers stay in mem_access_unit.

Test Plan:
- Reset mid-load: accept a load of 70, assert reset_n=0 in cycle N+2 -> all outputs 0 immediately, wb_valid never pulses, req_ready=1 after release.
- Store 8'hA5 to 64, then load 64 into rd=3 -> mem_write_enable high for exactly one cycle with mem_address=64; wb_valid at accept+3 with wb_rd=3, wb_data=8'hA5.
- Boundary: loads of 63, 64, 127, 128 ->
  - 63 and 128: fault pulse with fault_addr=63 and fault_addr=128 respectively, mem_write_enable stays 0, no wb_valid.
  - 64 and 127: normal wb_valid.
- Store to 200 with req_wdata=8'hFF -> fault=1 for one cycle with fault_addr=200, mem_write_enable never asserts, memory contents unchanged (a follow-up load of a preloaded address returns its preload value).
- Back-to-back: req_valid held high with load 65, then store 66, then load 66 -> req_ready low during busy states; requests accepted at cycles 0, 4, 6; final wb_data equals the stored value.
- Busy-ignore: change req_addr while in LOAD -> mem_address and wb_rd reflect only the accepted request.
